// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite plotter slice.
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_DONE
    } state_e;

    localparam int DEFAULT_SCREEN_W = 320;
    localparam int DEFAULT_SCREEN_H = 240;
    localparam int DEFAULT_COLOR_W  = 3;

    // 4x4 airplane, bit (row*4+col), bit 0 = top-left
    localparam logic [15:0] AIRPLANE_MASK = 16'h62F2;

endpackage

// File: rtl/sprite_plotter_if.sv
// Request/pixel bundle between a game control FSM, the plotter and the VGA adapter.
interface sprite_plotter_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = sprite_pkg::DEFAULT_COLOR_W,
    parameter int SPR_W   = 4,
    parameter int SPR_H   = 4
);
    logic                     start;
    logic                     erase;
    logic [X_W-1:0]           x_in;
    logic [Y_W-1:0]           y_in;
    logic [COLOR_W-1:0]       color_in;
    logic [COLOR_W-1:0]       bg_color_in;
    logic [SPR_W*SPR_H-1:0]   mask_in;
    logic [X_W-1:0]           x_out;
    logic [Y_W-1:0]           y_out;
    logic [COLOR_W-1:0]       color_out;
    logic                     plot;
    logic                     busy;
    logic                     done;

    modport master (
        output start, erase, x_in, y_in, color_in, bg_color_in, mask_in,
        input  x_out, y_out, color_out, plot, busy, done
    );

    modport slave (
        input  start, erase, x_in, y_in, color_in, bg_color_in, mask_in,
        output x_out, y_out, color_out, plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter_wrap_counter.sv
// Counter 0..MAX with synchronous clear; wrap flags the enabled MAX->0 step.
module wrap_counter #(
    parameter int MAX = 3,
    parameter int W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         wrap
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        wrap    = enable && (count_q == MAX_V);
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/sprite_plotter.sv
// Masked, clipped SPR_W x SPR_H sprite rasteriser: one VGA pixel write per cycle.
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = DEFAULT_COLOR_W,
    parameter int SPR_W    = 4,
    parameter int SPR_H    = 4,
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H
) (
    input  logic             clk,
    input  logic             reset_n,
    sprite_plotter_if.slave  bus
);
    localparam int N     = SPR_W * SPR_H;
    localparam int CX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int CY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [N-1:0]       mask_q, mask_d;

    logic               draw_en;
    logic [CX_W-1:0]    cx;
    logic [CY_W-1:0]    cy;
    logic               cx_wrap, cy_wrap;

    logic [X_W:0]       x_sum;
    logic [Y_W:0]       y_sum;
    logic [IDX_W-1:0]   pix_idx;
    logic               on_screen;

    assign draw_en = (state_q == ST_DRAW);

    // cy only advances on cx wrap, so cy's wrap marks the final pixel
    wrap_counter #(.MAX(SPR_W - 1), .W(CX_W)) u_cx (
        .clk(clk), .reset_n(reset_n), .clear(!draw_en), .enable(draw_en),
        .count(cx), .wrap(cx_wrap)
    );

    wrap_counter #(.MAX(SPR_H - 1), .W(CY_W)) u_cy (
        .clk(clk), .reset_n(reset_n), .clear(!draw_en), .enable(cx_wrap),
        .count(cy), .wrap(cy_wrap)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_DRAW;
                    x_d     = bus.x_in;
                    y_d     = bus.y_in;
                    mask_d  = bus.mask_in;
                    color_d = bus.erase ? bus.bg_color_in : bus.color_in;
                end
            end
            ST_DRAW: if (cy_wrap) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            mask_q  <= mask_d;
        end
    end

    // Sums carry one extra bit so wrapped coordinates still clip
    always_comb begin
        x_sum     = {1'b0, x_q} + (X_W + 1)'(cx);
        y_sum     = {1'b0, y_q} + (Y_W + 1)'(cy);
        pix_idx   = IDX_W'(cy) * IDX_W'(SPR_W) + IDX_W'(cx);
        on_screen = (x_sum < (X_W + 1)'(SCREEN_W)) && (y_sum < (Y_W + 1)'(SCREEN_H));

        bus.x_out     = '0;
        bus.y_out     = '0;
        bus.color_out = '0;
        bus.plot      = 1'b0;
        bus.busy      = draw_en;
        bus.done      = (state_q == ST_DONE);
        if (draw_en) begin
            bus.x_out     = x_sum[X_W-1:0];
            bus.y_out     = y_sum[Y_W-1:0];
            bus.color_out = color_q;
            bus.plot      = mask_q[pix_idx] && on_screen;
        end
    end
endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: 4x4 and 8x2 instances, hand-derived pixel streams.
module tb_sprite_plotter;
    import sprite_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sprite_plotter_if #(.X_W(9), .Y_W(8), .COLOR_W(3), .SPR_W(4), .SPR_H(4)) b4 ();
    sprite_plotter_if #(.X_W(9), .Y_W(8), .COLOR_W(3), .SPR_W(8), .SPR_H(2)) b8 ();

    sprite_plotter #(.X_W(9), .Y_W(8), .COLOR_W(3), .SPR_W(4), .SPR_H(4),
                     .SCREEN_W(320), .SCREEN_H(240)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(b4.slave)
    );

    sprite_plotter #(.X_W(9), .Y_W(8), .COLOR_W(3), .SPR_W(8), .SPR_H(2),
                     .SCREEN_W(320), .SCREEN_H(240)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(b8.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle4(input string tag);
        chk({tag, "_x"},     32'(b4.x_out), 32'd0);
        chk({tag, "_y"},     32'(b4.y_out), 32'd0);
        chk({tag, "_col"},   32'(b4.color_out), 32'd0);
        chk({tag, "_plot"},  32'(b4.plot), 32'd0);
        chk({tag, "_busy"},  32'(b4.busy), 32'd0);
        chk({tag, "_done"},  32'(b4.done), 32'd0);
    endtask

    // Full 4x4 draw; inputs are scrambled after start to prove they were latched.
    // poke re-pulses start at pixel 4 and during DONE, leaving start high on return.
    task automatic draw4(input string tag, input logic [8:0] x, input logic [7:0] y,
                         input logic [2:0] fg, input logic [2:0] bg, input logic er,
                         input logic [15:0] m, input bit poke, input int exp_plots);
        int plots;
        int ex, ey;
        plots = 0;
        b4.x_in = x; b4.y_in = y; b4.color_in = fg; b4.bg_color_in = bg;
        b4.erase = er; b4.mask_in = m; b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        b4.x_in = ~x; b4.y_in = ~y; b4.color_in = ~fg; b4.bg_color_in = ~bg;
        b4.erase = ~er; b4.mask_in = ~m;
        for (int k = 0; k < 16; k++) begin
            ex = int'(x) + k % 4;
            ey = int'(y) + k / 4;
            chk({tag, "_x"},    32'(b4.x_out), 32'(ex[8:0]));
            chk({tag, "_y"},    32'(b4.y_out), 32'(ey[7:0]));
            chk({tag, "_col"},  32'(b4.color_out), 32'(er ? bg : fg));
            chk({tag, "_plot"}, 32'(b4.plot), 32'(m[k] && ex < 320 && ey < 240));
            chk({tag, "_busy"}, 32'(b4.busy), 32'd1);
            chk({tag, "_done"}, 32'(b4.done), 32'd0);
            plots += int'(b4.plot);
            b4.start = poke && (k == 4);
            tick();
        end
        chk({tag, "_done_hi"},   32'(b4.done), 32'd1);
        chk({tag, "_done_busy"}, 32'(b4.busy), 32'd0);
        chk({tag, "_done_plot"}, 32'(b4.plot), 32'd0);
        chk({tag, "_nplots"},    32'(plots), 32'(exp_plots));
        b4.start = poke;
        tick();
        chk({tag, "_idle_done"}, 32'(b4.done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(b4.busy), 32'd0);
    endtask

    initial begin
        int ex, ey;
        b4.start = 1'b0; b4.erase = 1'b0; b4.x_in = '0; b4.y_in = '0;
        b4.color_in = '0; b4.bg_color_in = '0; b4.mask_in = '0;
        b8.start = 1'b0; b8.erase = 1'b0; b8.x_in = '0; b8.y_in = '0;
        b8.color_in = '0; b8.bg_color_in = '0; b8.mask_in = '0;

        reset_n = 1'b0;
        tick();
        tick();
        chk_idle4("reset");
        reset_n = 1'b1;
        tick();

        draw4("full",   9'd10,  8'd20,  3'b101, 3'b000, 1'b0, 16'hFFFF, 1'b0, 16);
        draw4("mask",   9'd10,  8'd20,  3'b101, 3'b000, 1'b0, 16'h8421, 1'b0, 4);
        draw4("erase",  9'd10,  8'd20,  3'b101, 3'b000, 1'b1, 16'hFFFF, 1'b0, 16);
        draw4("erasem", 9'd10,  8'd20,  3'b101, 3'b010, 1'b1, 16'h8421, 1'b0, 4);
        draw4("clip",   9'd318, 8'd238, 3'b110, 3'b000, 1'b0, 16'hFFFF, 1'b0, 4);
        draw4("wrap",   9'd510, 8'd254, 3'b011, 3'b000, 1'b0, 16'hFFFF, 1'b0, 0);
        draw4("plane",  9'd40,  8'd60,  3'b011, 3'b000, 1'b0, AIRPLANE_MASK, 1'b0, 8);

        // Both pokes ignored; start held into the IDLE cycle is accepted.
        draw4("hs", 9'd100, 8'd100, 3'b001, 3'b000, 1'b0, 16'hFFFF, 1'b1, 16);
        b4.x_in = 9'd50; b4.y_in = 8'd60; b4.color_in = 3'b111; b4.erase = 1'b0;
        b4.mask_in = 16'hFFFF;
        tick();
        b4.start = 1'b0;
        chk("hs_next_busy", 32'(b4.busy), 32'd1);
        chk("hs_next_x",    32'(b4.x_out), 32'd50);
        chk("hs_next_y",    32'(b4.y_out), 32'd60);
        chk("hs_next_col",  32'(b4.color_out), 32'd7);
        repeat (16) tick();
        chk("hs_next_done", 32'(b4.done), 32'd1);
        tick();

        // Reset while pixel 7 (col 3, row 1) is on the outputs.
        b4.x_in = 9'd30; b4.y_in = 8'd40; b4.color_in = 3'b100; b4.mask_in = 16'hFFFF;
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        repeat (7) tick();
        chk("rst_px7_x", 32'(b4.x_out), 32'd33);
        chk("rst_px7_y", 32'(b4.y_out), 32'd41);
        reset_n = 1'b0;
        tick();
        chk_idle4("rst_mid");
        reset_n = 1'b1;
        tick();
        chk("rst_after_busy", 32'(b4.busy), 32'd0);
        chk("rst_after_done", 32'(b4.done), 32'd0);
        draw4("post_rst", 9'd30, 8'd40, 3'b100, 3'b000, 1'b0, 16'hFFFF, 1'b0, 16);

        // 8x2 instance: row wraps after x+7.
        b8.x_in = 9'd100; b8.y_in = 8'd50; b8.color_in = 3'b010; b8.mask_in = 16'hFFFF;
        b8.start = 1'b1;
        tick();
        b8.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ex = 100 + k % 8;
            ey = 50 + k / 8;
            chk("w8_x",    32'(b8.x_out), 32'(ex));
            chk("w8_y",    32'(b8.y_out), 32'(ey));
            chk("w8_plot", 32'(b8.plot), 32'd1);
            chk("w8_busy", 32'(b8.busy), 32'd1);
            tick();
        end
        chk("w8_done", 32'(b8.done), 32'd1);
        chk("w8_busy_off", 32'(b8.busy), 32'd0);
        tick();
        chk("w8_done_off", 32'(b8.done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
